// File: rtl/instr_issue_buffer.sv
// Fetch-to-decode decoupling buffer: LANES-wide push/pop circular queue of {instr, pc}
// with first-word-fall-through head lanes, branch flush and sticky overflow.
module instr_issue_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 2,
  parameter int DEPTH      = 8,
  parameter int CW         = $clog2(LANES + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [CW-1:0]                 in_count,
  input  logic [LANES*DATA_WIDTH-1:0]   in_instr,
  input  logic [DATA_WIDTH-1:0]         in_pc,
  output logic                          in_ready,
  output logic [LANES-1:0]              out_valid,
  output logic [LANES*DATA_WIDTH-1:0]   out_instr,
  output logic [LANES*DATA_WIDTH-1:0]   out_pc,
  input  logic [CW-1:0]                 out_take,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  logic [DATA_WIDTH-1:0] instr_mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] pc_mem_r    [DEPTH];
  logic [AW-1:0]         rd_ptr_r;
  logic [AW-1:0]         wr_ptr_r;
  logic [NW-1:0]         count_r;
  logic                  overflow_r;

  logic                  in_ready_s;
  logic                  push_ok_s;
  logic                  drop_s;
  logic [CW-1:0]         push_n_s;
  logic [NW-1:0]         pop_n_s;

  // Readiness depends only on the count register so fetch never sees a path from decode.
  always_comb begin
    in_ready_s = (NW'(DEPTH) - count_r) >= NW'(LANES);
    push_ok_s  = in_valid && in_ready_s && !flush;
    drop_s     = in_valid && (in_count != '0) && !in_ready_s && !flush;
    if (push_ok_s) begin
      push_n_s = (in_count > CW'(LANES)) ? CW'(LANES) : in_count;
    end else begin
      push_n_s = '0;
    end
    if (NW'(out_take) > count_r) begin
      pop_n_s = count_r;
    end else begin
      pop_n_s = NW'(out_take);
    end
  end

  // Pointer/occupancy update; flush wins over push and pop but leaves overflow alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr_r <= '0;
        wr_ptr_r <= '0;
        count_r  <= '0;
      end else begin
        wr_ptr_r <= wr_ptr_r + AW'(push_n_s);
        rd_ptr_r <= rd_ptr_r + AW'(pop_n_s);
        count_r  <= count_r + NW'(push_n_s) - pop_n_s;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  // Entry storage: lane i of an accepted group lands at wr_ptr+i, PC derived from lane 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        instr_mem_r[e] <= '0;
        pc_mem_r[e]    <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (CW'(i) < push_n_s) begin
          instr_mem_r[AW'(wr_ptr_r + AW'(i))] <= in_instr[i*DATA_WIDTH +: DATA_WIDTH];
          pc_mem_r[AW'(wr_ptr_r + AW'(i))]    <= in_pc + (DATA_WIDTH'(i) << 2);
        end else begin
          instr_mem_r[AW'(wr_ptr_r + AW'(i))] <= instr_mem_r[AW'(wr_ptr_r + AW'(i))];
          pc_mem_r[AW'(wr_ptr_r + AW'(i))]    <= pc_mem_r[AW'(wr_ptr_r + AW'(i))];
        end
      end
    end
  end

  // Head lanes fall through from rd_ptr; empty lanes show a NOP at PC 0.
  always_comb begin
    out_valid = '0;
    out_instr = '0;
    out_pc    = '0;
    for (int i = 0; i < LANES; i++) begin
      if (NW'(i) < count_r) begin
        out_valid[i]                         = 1'b1;
        out_instr[i*DATA_WIDTH +: DATA_WIDTH] = instr_mem_r[AW'(rd_ptr_r + AW'(i))];
        out_pc[i*DATA_WIDTH +: DATA_WIDTH]    = pc_mem_r[AW'(rd_ptr_r + AW'(i))];
      end else begin
        out_valid[i]                         = 1'b0;
        out_instr[i*DATA_WIDTH +: DATA_WIDTH] = NOP;
        out_pc[i*DATA_WIDTH +: DATA_WIDTH]    = '0;
      end
    end
  end

  assign in_ready = in_ready_s;
  assign count    = count_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_instr_issue_buffer.sv
// Directed table-driven bench for instr_issue_buffer (LANES=2, DEPTH=8).
module tb_instr_issue_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_count = 2'd0;
  logic [63:0] in_instr = 64'd0;
  logic [31:0] in_pc = 32'd0;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [63:0] out_instr;
  logic [63:0] out_pc;
  logic [1:0]  out_take = 2'd0;
  logic [3:0]  count;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  instr_issue_buffer #(.DATA_WIDTH(32), .LANES(2), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_count(in_count),
    .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc(out_pc), .out_take(out_take), .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          fl;
    bit          iv;
    int          ic;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [31:0] pc;
    int          take;
    int          e_cnt;
    logic [1:0]  e_vld;
    bit          e_rdy;
    bit          e_ovf;
    logic [31:0] e_i0;
    logic [31:0] e_p0;
    logic [31:0] e_i1;
    logic [31:0] e_p1;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] ins(input logic [31:0] p);
    return 32'hA000_0000 | p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Push group at pc (lanes ins(pc), ins(pc+4)); expected head starts at hp.
  task automatic addp(input bit fl, input bit iv, input int ic, input logic [31:0] pc,
                      input int take, input int ecnt, input bit erdy, input bit eovf,
                      input logic [31:0] hp);
    vec_t v;
    v.fl = fl; v.iv = iv; v.ic = ic; v.pc = pc; v.take = take;
    v.i0 = ins(pc); v.i1 = ins(pc + 32'd4);
    v.e_cnt = ecnt; v.e_rdy = erdy; v.e_ovf = eovf;
    v.e_vld = (ecnt >= 2) ? 2'b11 : (ecnt == 1) ? 2'b01 : 2'b00;
    v.e_i0 = (ecnt >= 1) ? ins(hp) : NOP;
    v.e_p0 = (ecnt >= 1) ? hp : 32'd0;
    v.e_i1 = (ecnt >= 2) ? ins(hp + 32'd4) : NOP;
    v.e_p1 = (ecnt >= 2) ? hp + 32'd4 : 32'd0;
    tbl.push_back(v);
  endtask

  initial begin
    // Stimulus table, applied from reset in order.
    tbl.push_back('{0, 1, 2, 32'h00500093, 32'h00A00113, 32'h0, 0,
                    2, 2'b11, 1, 0, 32'h00500093, 32'h0, 32'h00A00113, 32'h4});
    tbl.push_back('{0, 0, 0, 32'h0, 32'h0, 32'h0, 1,
                    1, 2'b01, 1, 0, 32'h00A00113, 32'h4, NOP, 32'h0});
    addp(0, 0, 0, 32'h0,   2, 0, 1, 0, 32'h0);    // take clamp: 1 left, take 2
    addp(0, 1, 1, 32'h100, 0, 1, 1, 0, 32'h100);  // partial push
    addp(0, 0, 0, 32'h0,   1, 0, 1, 0, 32'h0);
    addp(0, 1, 2, 32'h200, 0, 2, 1, 0, 32'h200);
    addp(0, 1, 2, 32'h208, 0, 4, 1, 0, 32'h200);
    addp(0, 1, 2, 32'h210, 0, 6, 1, 0, 32'h200);
    addp(0, 1, 2, 32'h218, 0, 8, 0, 0, 32'h200);  // full
    addp(0, 1, 2, 32'h300, 0, 8, 0, 1, 32'h200);  // dropped, overflow
    addp(0, 0, 0, 32'h0,   2, 6, 1, 1, 32'h208);
    addp(0, 1, 2, 32'h220, 2, 6, 1, 1, 32'h210);  // push+pop at DEPTH-LANES
    addp(0, 0, 0, 32'h0,   2, 4, 1, 1, 32'h218);
    addp(0, 1, 2, 32'h228, 2, 4, 1, 1, 32'h220);  // steady traffic across wrap
    addp(0, 1, 2, 32'h230, 2, 4, 1, 1, 32'h228);
    addp(0, 1, 2, 32'h238, 2, 4, 1, 1, 32'h230);
    addp(0, 1, 2, 32'h240, 2, 4, 1, 1, 32'h238);
    addp(0, 1, 2, 32'h248, 2, 4, 1, 1, 32'h240);
    addp(0, 1, 2, 32'h250, 2, 4, 1, 1, 32'h248);
    addp(0, 1, 2, 32'h258, 0, 6, 1, 1, 32'h248);
    addp(1, 1, 2, 32'h400, 2, 0, 1, 1, 32'h0);    // flush beats push and take
    addp(0, 1, 1, 32'h500, 0, 1, 1, 1, 32'h500);
    addp(0, 1, 0, 32'h600, 0, 1, 1, 1, 32'h500);  // in_count=0 is a no-op
    addp(0, 1, 2, 32'hFFFF_FFFC, 1, 2, 1, 1, 32'hFFFF_FFFC);  // lane PC wraps to 0
    addp(0, 1, 3, 32'h600, 0, 4, 1, 1, 32'hFFFF_FFFC);        // in_count clamps to LANES

    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_ready", 64'(in_ready), 64'd1);
    chk("reset_ovf", 64'(overflow), 64'd0);
    chk("reset_instr", out_instr, {NOP, NOP});
    chk("reset_pc", out_pc, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      flush    = tbl[k].fl;
      in_valid = tbl[k].iv;
      in_count = 2'(tbl[k].ic);
      in_instr = {tbl[k].i1, tbl[k].i0};
      in_pc    = tbl[k].pc;
      out_take = 2'(tbl[k].take);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_count", k), 64'(count), 64'(tbl[k].e_cnt));
      chk($sformatf("v%0d_valid", k), 64'(out_valid), 64'(tbl[k].e_vld));
      chk($sformatf("v%0d_ready", k), 64'(in_ready), 64'(tbl[k].e_rdy));
      chk($sformatf("v%0d_ovf", k), 64'(overflow), 64'(tbl[k].e_ovf));
      chk($sformatf("v%0d_instr", k), out_instr, {tbl[k].e_i1, tbl[k].e_i0});
      chk($sformatf("v%0d_pc", k), out_pc, {tbl[k].e_p1, tbl[k].e_p0});
      @(negedge clk);
    end

    // Asynchronous reset mid-cycle clears a non-empty buffer and sticky overflow at once.
    flush = 1'b0; in_valid = 1'b0; in_count = 2'd0; out_take = 2'd0;
    #2;
    rst = 1'b0;
    #1;
    chk("areset_count", 64'(count), 64'd0);
    chk("areset_valid", 64'(out_valid), 64'd0);
    chk("areset_ready", 64'(in_ready), 64'd1);
    chk("areset_ovf", 64'(overflow), 64'd0);
    chk("areset_instr", out_instr, {NOP, NOP});
    chk("areset_pc", out_pc, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Pushed entry is not visible before the push edge (no bypass).
    in_valid = 1'b1; in_count = 2'd2; in_pc = 32'h700;
    in_instr = {ins(32'h704), ins(32'h700)};
    #1;
    chk("nobypass_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("bypass_after_edge", {out_pc[31:0], out_instr[31:0]}, {32'h700, ins(32'h700)});
    @(negedge clk);
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_issue_buffer.md
Name: instr_issue_buffer

Overview:
- Parametrised fetch-to-decode decoupling buffer for the N-lane superscalar core.
- Generalises the fixed two-lane, unbuffered fetch→decode path to LANES lanes.
- Fetch pushes up to LANES instructions per cycle; decode pops up to LANES per cycle, in program order.
- Adds a flush for taken branches and sticky overflow detection.

Parameters:
DATA_WIDTH, 32, instruction and PC width
LANES, 2, instructions per push/pop group (≥1)
DEPTH, 8, buffer entries; power of 2, ≥ 2*LANES
CW (derived), $clog2(LANES+1), width of lane-count fields

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
flush  input  1  discard all contents (PCSrc taken / redirect)
in_valid  input  1  push group present
in_count  input  CW  number of valid lanes in push group (lanes 0..in_count-1)
in_instr  input  LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
in_pc  input  DATA_WIDTH  PC of lane 0; lane i PC = in_pc + 4*i
in_ready  output  1  buffer can accept a full group
out_valid  output  LANES  thermometer, bit i set iff count > i
out_instr  output  LANES*DATA_WIDTH  head instructions, lane 0 = oldest
out_pc  output  LANES*DATA_WIDTH  PCs matching out_instr
out_take  input  CW  number of head entries consumed this cycle
count  output  $clog2(DEPTH+1)  current occupancy
overflow  output  1  sticky: push attempted while !in_ready

Behaviour:
- Storage: circular array of {instr, pc}; rd_ptr/wr_ptr mod DEPTH, registered count.
- Reset (rst=0, asynchronous):
  - rd_ptr=wr_ptr=0, count=0, overflow=0.
  - Outputs: out_valid=0, in_ready=1.
  - out_instr all lanes 0x00000013 (NOP), out_pc all 0.
- in_ready = (DEPTH − count) ≥ LANES. Combinational from the count register only; no dependency on out_take.
- Push amount:
  - push_n = min(in_count, LANES) when in_valid && in_ready && !flush; else 0.
  - in_count=0 with in_valid: no-op.
- Pop amount: pop_n = min(out_take, count); excess take is clamped silently.
- Clocked update, no flush:
  - Entries written at wr_ptr..wr_ptr+push_n−1 (wrapping).
  - wr_ptr += push_n, rd_ptr += pop_n, count += push_n − pop_n.
  - Simultaneous push and pop are legal in every state, including count=DEPTH−LANES.
- Outputs: first-word-fall-through from rd_ptr, combinational from registered state.
  - No write-to-read bypass: a pushed entry appears on out_* the cycle after the push edge.
  - Lanes i ≥ count drive out_instr=NOP and out_pc=0.
- Flush: synchronous and highest priority.
  - On the edge: rd_ptr=wr_ptr=0, count=0.
  - A push and any out_take in the same cycle are ignored.
  - overflow is not cleared.
- Overflow:
  - in_valid && in_count≠0 && !in_ready && !flush sets overflow=1.
  - The group is dropped and the buffer is unchanged.
  - Cleared only by reset.
- Program order is preserved across pointer wrap-around.
- The lane-0 PC increment (in_pc + 4*i) wraps modulo 2^DATA_WIDTH.

Test Plan:
- Reset: drive rst=0 mid-cycle → immediately count=0, out_valid=00, in_ready=1, out_instr={0x00000013,0x00000013}, overflow=0.
- Push 2 / pop 1:
  - Push in_count=2, instrs {0x00500093, 0x00A00113}, in_pc=0x0.
  - Next cycle: out_valid=11, out_pc={0x0,0x4}, count=2.
  - Then out_take=1 → next cycle count=1, lane0=0x00A00113 pc 0x4, out_valid=01, lane1=NOP.
- Full and overflow:
  - 4 pushes of 2 with out_take=0 → count=8, in_ready=0.
  - A 5th push → dropped, overflow=1, count stays 8.
  - out_take=2 → count=6, in_ready=1, overflow remains 1.
- Wrap with simultaneous traffic:
  - Hold count=4 near the array end; push 2 and pop 2 each cycle for 6 cycles.
  - count stays 4; popped PCs are strictly sequential (+4) across the wrap.
- Flush priority: count=6, flush=1 with in_valid=1, in_count=2, out_take=2 → next cycle count=0, out_valid=00, in_ready=1, pushed group absent.
- Take clamp and partial push:
  - count=1, out_take=2 → count=0, no underflow.
  - Then push in_count=1 → out_valid=01, lane1=NOP.
